// File: rtl/page_table_responder.sv
// page_table_responder: page-walk responder serving the 8B-page and 32B-page
// lookup ports of the speculative TLB. Each port has its own IDLE/WALK/DONE
// FSM with a fixed walk latency. Translation tables can be written at run time
// and signal faults through their valid bits.
// Optional feature macro: PT_STATS_EN builds the saturating STAT_LOOKUPS /
// STAT_FAULTS counters. When it is undefined, both outputs are tied to zero.
module page_table_responder #(
  parameter int         LAT_8B  = 4,
  parameter int         LAT_32B = 2,
  parameter logic [5:0] KEY_8B  = 6'h15,
  parameter logic [3:0] KEY_32B = 4'h5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        LOOKUP_RQST_8B,
  input  logic [5:0]  LOOKUP_ADDR_8B,
  output logic        LOOKUP_COMPLETE_8B,
  output logic [11:0] LOOKUP_RETURN_8B,
  output logic        LOOKUP_VALID_8B,
  input  logic        LOOKUP_RQST_32B,
  input  logic [3:0]  LOOKUP_ADDR_32B,
  output logic        LOOKUP_COMPLETE_32B,
  output logic [7:0]  LOOKUP_RETURN_32B,
  output logic        LOOKUP_VALID_32B,
  input  logic        PT_WR_EN,
  input  logic        PT_WR_SEL,
  input  logic [5:0]  PT_WR_ADDR,
  input  logic [5:0]  PT_WR_PPN,
  input  logic        PT_WR_VALID,
  output logic [15:0] STAT_LOOKUPS,
  output logic [15:0] STAT_FAULTS
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WALK = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // The counter is loaded with LAT-1 so that the table read lands on edge N+LAT.
  localparam logic [3:0] LAT8_M1  = 4'(LAT_8B - 1);
  localparam logic [3:0] LAT32_M1 = 4'(LAT_32B - 1);

  // Translation tables: PPN and valid bit per entry
  logic [5:0]  r_tbl8_ppn [64];
  logic [63:0] r_tbl8_vld;
  logic [3:0]  r_tbl32_ppn [16];
  logic [15:0] r_tbl32_vld;

  // Per-port FSM state
  logic [1:0]  r_st8,  r_st32;
  logic [3:0]  r_cnt8, r_cnt32;
  logic [5:0]  r_vpn8;
  logic [3:0]  r_vpn32;
  logic [11:0] r_ret8;
  logic [7:0]  r_ret32;
  logic        r_vld8, r_vld32;

  // A read edge is the last WALK cycle, when the counter has reached zero.
  logic w_rd8, w_rd32;
  assign w_rd8  = (r_st8  == S_WALK) && (r_cnt8  == 4'd0);
  assign w_rd32 = (r_st32 == S_WALK) && (r_cnt32 == 4'd0);

  // Table storage: reset loads the key mapping. Writes use nonblocking
  // assignment, so a walk reading the same entry on the same edge sees the old
  // contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        r_tbl8_ppn[i] <= 6'(i) ^ KEY_8B;
      end
      for (int j = 0; j < 16; j++) begin
        r_tbl32_ppn[j] <= 4'(j) ^ KEY_32B;
      end
      r_tbl8_vld  <= '1;
      r_tbl32_vld <= '1;
    end else if (PT_WR_EN) begin
      if (!PT_WR_SEL) begin
        r_tbl8_ppn[PT_WR_ADDR] <= PT_WR_PPN;
        r_tbl8_vld[PT_WR_ADDR] <= PT_WR_VALID;
      end else begin
        r_tbl32_ppn[PT_WR_ADDR[3:0]] <= PT_WR_PPN[3:0];
        r_tbl32_vld[PT_WR_ADDR[3:0]] <= PT_WR_VALID;
      end
    end
  end

  // 8B port FSM: accept in IDLE, count down in WALK, pulse COMPLETE in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st8  <= S_IDLE;
      r_cnt8 <= 4'd0;
      r_vpn8 <= 6'd0;
      r_ret8 <= 12'd0;
      r_vld8 <= 1'b0;
    end else begin
      case (r_st8)
        S_IDLE: begin
          if (LOOKUP_RQST_8B) begin
            r_vpn8 <= LOOKUP_ADDR_8B;
            r_cnt8 <= LAT8_M1;
            r_st8  <= S_WALK;
          end
        end
        S_WALK: begin
          if (w_rd8) begin
            r_ret8 <= {r_vpn8, r_tbl8_ppn[r_vpn8]};
            r_vld8 <= r_tbl8_vld[r_vpn8];
            r_st8  <= S_DONE;
          end else begin
            r_cnt8 <= r_cnt8 - 4'd1;
          end
        end
        S_DONE:  r_st8 <= S_IDLE;
        default: r_st8 <= S_IDLE;
      endcase
    end
  end

  // 32B port FSM: same structure as the 8B port, using the narrower table
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st32  <= S_IDLE;
      r_cnt32 <= 4'd0;
      r_vpn32 <= 4'd0;
      r_ret32 <= 8'd0;
      r_vld32 <= 1'b0;
    end else begin
      case (r_st32)
        S_IDLE: begin
          if (LOOKUP_RQST_32B) begin
            r_vpn32 <= LOOKUP_ADDR_32B;
            r_cnt32 <= LAT32_M1;
            r_st32  <= S_WALK;
          end
        end
        S_WALK: begin
          if (w_rd32) begin
            r_ret32 <= {r_vpn32, r_tbl32_ppn[r_vpn32]};
            r_vld32 <= r_tbl32_vld[r_vpn32];
            r_st32  <= S_DONE;
          end else begin
            r_cnt32 <= r_cnt32 - 4'd1;
          end
        end
        S_DONE:  r_st32 <= S_IDLE;
        default: r_st32 <= S_IDLE;
      endcase
    end
  end

  assign LOOKUP_COMPLETE_8B  = (r_st8  == S_DONE);
  assign LOOKUP_RETURN_8B    = r_ret8;
  assign LOOKUP_VALID_8B     = r_vld8;
  assign LOOKUP_COMPLETE_32B = (r_st32 == S_DONE);
  assign LOOKUP_RETURN_32B   = r_ret32;
  assign LOOKUP_VALID_32B    = r_vld32;

`ifdef PT_STATS_EN
  logic [15:0] r_stat_lk, r_stat_flt;
  logic [1:0]  w_add_lk, w_add_flt;
  logic        w_flt8, w_flt32;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign w_flt8    = w_rd8  & ~r_tbl8_vld[r_vpn8];
  assign w_flt32   = w_rd32 & ~r_tbl32_vld[r_vpn32];
  assign w_add_lk  = {1'b0, w_rd8}  + {1'b0, w_rd32};
  assign w_add_flt = {1'b0, w_flt8} + {1'b0, w_flt32};

  // Counters update on the read edge, so they move together with COMPLETE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_lk  <= 16'd0;
      r_stat_flt <= 16'd0;
    end else begin
      r_stat_lk  <= sat_add(r_stat_lk,  w_add_lk);
      r_stat_flt <= sat_add(r_stat_flt, w_add_flt);
    end
  end

  assign STAT_LOOKUPS = r_stat_lk;
  assign STAT_FAULTS  = r_stat_flt;
`else
  assign STAT_LOOKUPS = 16'h0000;
  assign STAT_FAULTS  = 16'h0000;
`endif

endmodule

// File: tb/tb_page_table_responder.sv
// tb_page_table_responder: directed vectors with a scoreboard. Stimulus pushes
// the hand-computed response and completion cycle into a per-port queue. A
// negedge monitor pops an entry and compares it whenever a COMPLETE pulse
// appears.
module tb_page_table_responder;
  localparam int LAT8  = 4;
  localparam int LAT32 = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rq8 = 1'b0;
  logic [5:0]  ad8 = '0;
  logic        cp8;
  logic [11:0] rt8;
  logic        vl8;
  logic        rq32 = 1'b0;
  logic [3:0]  ad32 = '0;
  logic        cp32;
  logic [7:0]  rt32;
  logic        vl32;
  logic        wen = 1'b0;
  logic        wsel = 1'b0;
  logic [5:0]  waddr = '0;
  logic [5:0]  wppn = '0;
  logic        wvld = 1'b0;
  logic [15:0] st_lk, st_flt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [11:0] ret;
    logic        vld;
    int          cyc;
  } exp_t;
  exp_t q8[$];
  exp_t q32[$];

  page_table_responder #(.LAT_8B(LAT8), .LAT_32B(LAT32)) dut (
    .clk(clk), .rst(rst),
    .LOOKUP_RQST_8B(rq8), .LOOKUP_ADDR_8B(ad8),
    .LOOKUP_COMPLETE_8B(cp8), .LOOKUP_RETURN_8B(rt8), .LOOKUP_VALID_8B(vl8),
    .LOOKUP_RQST_32B(rq32), .LOOKUP_ADDR_32B(ad32),
    .LOOKUP_COMPLETE_32B(cp32), .LOOKUP_RETURN_32B(rt32), .LOOKUP_VALID_32B(vl32),
    .PT_WR_EN(wen), .PT_WR_SEL(wsel), .PT_WR_ADDR(waddr),
    .PT_WR_PPN(wppn), .PT_WR_VALID(wvld),
    .STAT_LOOKUPS(st_lk), .STAT_FAULTS(st_flt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // The counters read zero when the statistics feature is not built.
  function automatic int st(input int v);
`ifdef PT_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cp8"},  {31'd0, cp8},  32'd0);
    check({tag, "_rt8"},  {20'd0, rt8},  32'd0);
    check({tag, "_vl8"},  {31'd0, vl8},  32'd0);
    check({tag, "_cp32"}, {31'd0, cp32}, 32'd0);
    check({tag, "_rt32"}, {24'd0, rt32}, 32'd0);
    check({tag, "_vl32"}, {31'd0, vl32}, 32'd0);
    check({tag, "_stlk"}, {16'd0, st_lk},  32'd0);
    check({tag, "_stflt"}, {16'd0, st_flt}, 32'd0);
  endtask

  // Called at a negedge: the accepting edge is the next posedge (cyc+1).
  task automatic push8(input logic [11:0] ret, input logic vld);
    q8.push_back('{ret: ret, vld: vld, cyc: cyc + 1 + LAT8});
  endtask

  task automatic push32(input logic [7:0] ret, input logic vld);
    q32.push_back('{ret: {4'd0, ret}, vld: vld, cyc: cyc + 1 + LAT32});
  endtask

  task automatic req8(input logic [5:0] a, input logic [11:0] ret, input logic vld);
    @(negedge clk);
    rq8 = 1'b1;
    ad8 = a;
    push8(ret, vld);
    @(negedge clk);
    rq8 = 1'b0;
  endtask

  task automatic req32(input logic [3:0] a, input logic [7:0] ret, input logic vld);
    @(negedge clk);
    rq32 = 1'b1;
    ad32 = a;
    push32(ret, vld);
    @(negedge clk);
    rq32 = 1'b0;
  endtask

  // Monitor: every COMPLETE pulse must match the head of its port's queue.
  always @(negedge clk) begin
    exp_t e;
    if (cp8 === 1'b1) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL c8_spurious at cycle %0d ret=%0h", cyc, rt8);
      end else begin
        e = q8.pop_front();
        check("ret8", {20'd0, rt8}, {20'd0, e.ret});
        check("vld8", {31'd0, vl8}, {31'd0, e.vld});
        check("lat8", cyc, e.cyc);
      end
    end
    if (cp32 === 1'b1) begin
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL c32_spurious at cycle %0d ret=%0h", cyc, rt32);
      end else begin
        e = q32.pop_front();
        check("ret32", {24'd0, rt32}, {20'd0, e.ret});
        check("vld32", {31'd0, vl32}, {31'd0, e.vld});
        check("lat32", cyc, e.cyc);
      end
    end
  end

  initial begin
    do_reset();
    check_zero("reset");

    // 8B lookup of 0x0A: PPN = 0x0A ^ 0x15 = 0x1F
    req8(6'h0A, {6'h0A, 6'h1F}, 1'b1);
    idle(8);
    check("stat_lk_t1", {16'd0, st_lk}, st(1));

    // Both ports at once: 0x3F^0x15 = 0x2A, 0x3^0x5 = 0x6
    do_reset();
    @(negedge clk);
    rq8 = 1'b1;  ad8 = 6'h3F;
    rq32 = 1'b1; ad32 = 4'h3;
    push8({6'h3F, 6'h2A}, 1'b1);
    push32({4'h3, 4'h6}, 1'b1);
    @(negedge clk);
    rq8 = 1'b0;
    rq32 = 1'b0;
    idle(8);
    check("stat_lk_t2", {16'd0, st_lk}, st(2));
    check("stat_flt_t2", {16'd0, st_flt}, st(0));

    // Invalidate 8B entry 0x0A with PPN 0x01, then look it up: fault
    @(negedge clk);
    wen = 1'b1; wsel = 1'b0; waddr = 6'h0A; wppn = 6'h01; wvld = 1'b0;
    @(negedge clk);
    wen = 1'b0;
    req8(6'h0A, {6'h0A, 6'h01}, 1'b0);
    idle(8);
    check("stat_lk_t3", {16'd0, st_lk}, st(3));
    check("stat_flt_t3", {16'd0, st_flt}, st(1));

    // Re-pulse during the walk is ignored: a single completion for 0x1
    @(negedge clk);
    rq32 = 1'b1; ad32 = 4'h1;
    push32({4'h1, 4'h4}, 1'b1);
    @(negedge clk);
    rq32 = 1'b0;
    @(negedge clk);
    rq32 = 1'b1; ad32 = 4'h9;
    @(negedge clk);
    rq32 = 1'b0;
    idle(8);
    check("stat_lk_t4", {16'd0, st_lk}, st(4));

    // Reset two cycles after acceptance aborts the walk
    @(negedge clk);
    rq8 = 1'b1; ad8 = 6'h05;
    @(negedge clk);
    rq8 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("abort");
    idle(8);
    // The table was reloaded by reset, so 0x0A maps to 0x1F again
    req8(6'h0A, {6'h0A, 6'h1F}, 1'b1);
    idle(8);

    // Write 32B entry 2 on the same edge as the walk reads it: old PPN 0x7
    @(negedge clk);
    rq32 = 1'b1; ad32 = 4'h2;
    push32({4'h2, 4'h7}, 1'b1);
    @(negedge clk);
    rq32 = 1'b0;
    @(negedge clk);
    wen = 1'b1; wsel = 1'b1; waddr = 6'h02; wppn = 6'h0C; wvld = 1'b1;
    @(negedge clk);
    wen = 1'b0;
    idle(6);
    req32(4'h2, {4'h2, 4'hC}, 1'b1);
    idle(6);
    check("stat_lk_end", {16'd0, st_lk}, st(3));

    check("q8_drained",  q8.size(),  0);
    check("q32_drained", q32.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
